demux4_router: RTL and testbench
================================

Name: demux4_router

Overview:
- Write-side counterpart of the datapath's 3-way select. It steers one incoming data word to one of three sink channels using a 2-bit select.
- Sits between the CPU store/writeback source and three slower sinks: data memory, LED register, seven-segment register.
- Each sink channel has a one-entry output buffer with a valid/ready handshake.
- Select 2'b11 is a drop channel: the word is accepted, discarded and counted.

Parameters:
- bits, 32, data word width.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- DataIn  input  bits  word to route.
- Signal  input  2  destination select: 00 ch0, 01 ch1, 10 ch2, 11 drop.
- InValid  input  1  DataIn/Signal valid this cycle.
- InReady  output  1  router can accept this cycle.
- DataOut0/1/2  output  bits  channel buffer contents.
- OutValid0/1/2  output  1  channel buffer holds a word.
- OutReady0/1/2  input  1  sink consumes the word this cycle.
- DropCount  output  CNT_W  number of dropped words, saturating.

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: all OutValidN=0, all DataOutN=0, DropCount=0. Reset overrides any same-cycle accept or drain.
- Accept = InValid & InReady.
- InReady is combinational:
  - Signal=11: InReady=1.
  - Otherwise: InReady = ~OutValidN | OutReadyN for the selected N.
- InReady must not depend on InValid.
- Per channel N, at the clock edge:
  - Accept to N, buffer empty: load DataIn, OutValidN<=1.
  - Accept to N while OutValidN & OutReadyN: pass-through. The old word leaves, the new word loads, OutValidN stays 1.
  - No accept to N, OutValidN & OutReadyN: OutValidN<=0. DataOutN holds its last value.
  - OutValidN & ~OutReadyN: hold. DataOutN and OutValidN are stable.
- Latency: an accepted word appears on DataOutN with OutValidN=1 one cycle after the accept edge.
- OutReadyN while OutValidN=0 is ignored.
- Only the selected channel loads. Other channels drain independently in the same cycle.
- Drop channel (Signal=11):
  - Accept increments DropCount by 1.
  - At all-ones it saturates and holds.
  - No channel buffer changes.
- Signal and DataIn are don't-care when InValid=0. No state changes from the input side.
- A blocked input (InValid=1, InReady=0) does not have to hold stable. The router only samples on accept.
- Ordering: words to the same channel leave in accept order. No ordering is defined across channels.
- Reset mid-transfer discards buffered words. No partial output follows reset.

Test Plan:
- Reset: drive rst=1 with InValid=1, Signal=00 -> after the edge OutValid0/1/2=0, DataOut0=0, DropCount=0; while rst is held, no load occurs.
- Single route: DataIn=0xDEADBEEF, Signal=01, InValid=1, OutReady1=1 for one cycle -> next cycle OutValid1=1, DataOut1=0xDEADBEEF; following cycle OutValid1=0; OutValid0=OutValid2=0 throughout.
- Backpressure: OutReady0=0, send 0x11 to ch0, then present 0x22 to ch0 -> InReady=0; DataOut0 stays 0x11. Raise OutReady0 -> same cycle InReady=1, 0x22 is accepted, next cycle DataOut0=0x22 with OutValid0 continuously 1.
- Cross-channel independence: ch0 full and stalled; send 0x33 to ch2 -> InReady=1, DataOut2=0x33 next cycle, DataOut0 unchanged.
- Drop saturation: CNT_W=8, 300 consecutive accepts with Signal=11 -> InReady=1 every cycle, DropCount=255 at the end, no OutValid asserted.
- Streaming: back-to-back words 1..16 to ch1 with OutReady1=1 -> InReady=1 every cycle, DataOut1 sequence 1..16 with 1-cycle latency, no gaps.

Source files
------------

// File: rtl/demux4_router.sv
//------------------------------------------------------------------------------
// Module   : demux4_router
// Brief    : Steers one data word to one of three buffered sink channels,
//            with a fourth select that drops the word and counts it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux4_router #(
  parameter int bits  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [bits-1:0]  DataIn,
  input  logic [1:0]       Signal,
  input  logic             InValid,
  output logic             InReady,
  output logic [bits-1:0]  DataOut0,
  output logic [bits-1:0]  DataOut1,
  output logic [bits-1:0]  DataOut2,
  output logic             OutValid0,
  output logic             OutValid1,
  output logic             OutValid2,
  input  logic             OutReady0,
  input  logic             OutReady1,
  input  logic             OutReady2,
  output logic [CNT_W-1:0] DropCount
);

  localparam logic [1:0] c_SEL_DROP = 2'b11;

  logic [2:0]       w_outReady;
  logic [2:0]       w_outValid;
  logic [bits-1:0]  w_dataOut [3];
  logic             w_inReady;
  logic             w_accept;
  logic [CNT_W-1:0] r_dropCount;

  assign w_outReady = {OutReady2, OutReady1, OutReady0};

  // A full buffer can still take a word when its sink drains it in the same cycle.
  always_comb begin
    w_inReady = 1'b1;
    case (Signal)
      2'b00:   w_inReady = ~w_outValid[0] | w_outReady[0];
      2'b01:   w_inReady = ~w_outValid[1] | w_outReady[1];
      2'b10:   w_inReady = ~w_outValid[2] | w_outReady[2];
      default: w_inReady = 1'b1;
    endcase
  end

  assign w_accept = InValid & w_inReady;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic            r_valid;
    logic [bits-1:0] r_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_accept && (Signal == 2'(gi))) begin
        r_valid <= 1'b1;
        r_data  <= DataIn;
      end else if (w_outReady[gi]) begin
        r_valid <= 1'b0;
      end
    end

    assign w_outValid[gi] = r_valid;
    assign w_dataOut[gi]  = r_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropCount <= '0;
    end else if (w_accept && (Signal == c_SEL_DROP) && (r_dropCount != {CNT_W{1'b1}})) begin
      r_dropCount <= r_dropCount + CNT_W'(1);
    end
  end

  assign InReady   = w_inReady;
  assign OutValid0 = w_outValid[0];
  assign OutValid1 = w_outValid[1];
  assign OutValid2 = w_outValid[2];
  assign DataOut0  = w_dataOut[0];
  assign DataOut1  = w_dataOut[1];
  assign DataOut2  = w_dataOut[2];
  assign DropCount = r_dropCount;

endmodule

`default_nettype wire

// File: tb/tb_demux4_router.sv
//------------------------------------------------------------------------------
// Module   : tb_demux4_router
// Brief    : Table vectors, directed sequences and random traffic against a
//            per-channel occupancy model for demux4_router.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux4_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DataIn;
  logic [1:0]  Signal;
  logic        InValid;
  logic        InReady;
  logic [31:0] DataOut0, DataOut1, DataOut2;
  logic        OutValid0, OutValid1, OutValid2;
  logic        OutReady0, OutReady1, OutReady2;
  logic [7:0]  DropCount;

  demux4_router #(.bits(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .DataIn(DataIn), .Signal(Signal), .InValid(InValid),
    .InReady(InReady), .DataOut0(DataOut0), .DataOut1(DataOut1), .DataOut2(DataOut2),
    .OutValid0(OutValid0), .OutValid1(OutValid1), .OutValid2(OutValid2),
    .OutReady0(OutReady0), .OutReady1(OutReady1), .OutReady2(OutReady2),
    .DropCount(DropCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: how many words each channel holds (0 or 1) and the last word it loaded.
  int          occ [3];
  logic [31:0] lastWord [3];
  int          drops;
  logic        lastRdy;

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic [31:0] d;
    logic [2:0]  rdy;
    logic        r;
    logic        eRdy;
    logic [2:0]  eVld;
    logic [31:0] e0, e1, e2;
    logic [7:0]  eDrop;
  } vec_t;

  vec_t tab [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus: drive, check InReady before the edge, advance the model, check outputs after.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [2:0] rdy, input logic r, input bit chkRdy);
    bit er;
    bit acc;
    InValid = v; Signal = s; DataIn = d;
    {OutReady2, OutReady1, OutReady0} = rdy;
    rst = r;
    #1;
    er = (s == 2'b11) ? 1'b1 : ((occ[s] == 0) || rdy[s]);
    lastRdy = InReady;
    if (chkRdy) chk("InReady", {31'b0, InReady}, {31'b0, er});
    acc = v && er;
    @(posedge clk);
    if (r) begin
      for (int n = 0; n < 3; n++) begin occ[n] = 0; lastWord[n] = 32'h0; end
      drops = 0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (occ[n] > 0 && rdy[n]) occ[n] = occ[n] - 1;
        if (acc && int'(s) == n) begin occ[n] = occ[n] + 1; lastWord[n] = d; end
      end
      if (acc && s == 2'b11 && drops < 255) drops = drops + 1;
    end
    #1;
    chk("OutValid0", {31'b0, OutValid0}, {31'b0, occ[0] > 0});
    chk("OutValid1", {31'b0, OutValid1}, {31'b0, occ[1] > 0});
    chk("OutValid2", {31'b0, OutValid2}, {31'b0, occ[2] > 0});
    chk("DataOut0", DataOut0, lastWord[0]);
    chk("DataOut1", DataOut1, lastWord[1]);
    chk("DataOut2", DataOut2, lastWord[2]);
    chk("DropCount", {24'b0, DropCount}, drops);
  endtask

  initial begin
    tab[0] = '{1'b1, 2'd1, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 3'b010, 32'h0,  32'hDEADBEEF, 32'h0,  8'd0};
    tab[1] = '{1'b0, 2'd0, 32'h0,        3'b010, 1'b0, 1'b1, 3'b000, 32'h0,  32'hDEADBEEF, 32'h0,  8'd0};
    tab[2] = '{1'b1, 2'd0, 32'h11,       3'b000, 1'b0, 1'b1, 3'b001, 32'h11, 32'hDEADBEEF, 32'h0,  8'd0};
    tab[3] = '{1'b1, 2'd0, 32'h22,       3'b000, 1'b0, 1'b0, 3'b001, 32'h11, 32'hDEADBEEF, 32'h0,  8'd0};
    tab[4] = '{1'b1, 2'd0, 32'h22,       3'b001, 1'b0, 1'b1, 3'b001, 32'h22, 32'hDEADBEEF, 32'h0,  8'd0};
    tab[5] = '{1'b1, 2'd2, 32'h33,       3'b000, 1'b0, 1'b1, 3'b101, 32'h22, 32'hDEADBEEF, 32'h33, 8'd0};
    tab[6] = '{1'b1, 2'd3, 32'h55,       3'b000, 1'b0, 1'b1, 3'b101, 32'h22, 32'hDEADBEEF, 32'h33, 8'd1};
    tab[7] = '{1'b1, 2'd2, 32'h44,       3'b100, 1'b0, 1'b1, 3'b101, 32'h22, 32'hDEADBEEF, 32'h44, 8'd1};
    tab[8] = '{1'b0, 2'd3, 32'h0,        3'b111, 1'b0, 1'b1, 3'b000, 32'h22, 32'hDEADBEEF, 32'h44, 8'd1};
    tab[9] = '{1'b1, 2'd1, 32'h77,       3'b000, 1'b1, 1'b1, 3'b000, 32'h0,  32'h0,        32'h0,  8'd0};

    for (int n = 0; n < 3; n++) begin occ[n] = 0; lastWord[n] = 32'h0; end
    drops = 0;

    // Reset with a valid word presented: nothing may load.
    @(posedge clk); #1;
    cycle(1'b1, 2'd0, 32'hAAAA5555, 3'b000, 1'b1, 1'b0);
    cycle(1'b1, 2'd0, 32'hAAAA5555, 3'b000, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      cycle(tab[i].v, tab[i].s, tab[i].d, tab[i].rdy, tab[i].r, 1'b1);
      chk($sformatf("tab%0d.InReady", i), {31'b0, lastRdy}, {31'b0, tab[i].eRdy});
      chk($sformatf("tab%0d.Valid", i), {29'b0, OutValid2, OutValid1, OutValid0}, {29'b0, tab[i].eVld});
      chk($sformatf("tab%0d.Data0", i), DataOut0, tab[i].e0);
      chk($sformatf("tab%0d.Data1", i), DataOut1, tab[i].e1);
      chk($sformatf("tab%0d.Data2", i), DataOut2, tab[i].e2);
      chk($sformatf("tab%0d.Drop", i), {24'b0, DropCount}, {24'b0, tab[i].eDrop});
    end

    // Drop saturation.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 2'd3, $urandom, 3'b000, 1'b0, 1'b1);
      chk("dropRdy", {31'b0, lastRdy}, 32'd1);
    end
    chk("dropSat", {24'b0, DropCount}, 32'd255);
    chk("dropNoValid", {29'b0, OutValid2, OutValid1, OutValid0}, 32'd0);

    // Streaming 1..16 into ch1 with no gaps.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 2'd1, 32'(i), 3'b010, 1'b0, 1'b1);
      chk("streamRdy", {31'b0, lastRdy}, 32'd1);
      chk("streamData", DataOut1, 32'(i));
      chk("streamValid", {31'b0, OutValid1}, 32'd1);
    end
    cycle(1'b0, 2'd1, 32'h0, 3'b010, 1'b0, 1'b1);
    chk("streamEnd", {31'b0, OutValid1}, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 49) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
